// File: rtl/clock_switch_sequencer.sv
// Sequences clock-switch requests onto the select input of a glitch-free clock mux.
// Switches to a dead clock are refused; accepted switches wait out mux settle time, then a minimum dwell.
module clock_switch_sequencer #(
  parameter int   SETTLE_CYCLES = 8,
  parameter int   DWELL_CYCLES  = 16,
  parameter int   SYNC_STAGES   = 2,
  parameter logic RESET_SELECT  = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic request_valid,
  input  logic request_select,
  output logic request_ready,
  output logic response_valid,
  output logic response_error,
  input  logic clock_0_alive,
  input  logic clock_1_alive,
  output logic select,
  output logic busy
);

  localparam int CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'((DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic             select_n;
  logic             rsp_vld_n, rsp_err_n;

  logic [SYNC_STAGES-1:0] alive_0_sync, alive_1_sync;
  logic                   target_alive;

  // Alive synchronizers: cleared by reset so both clocks start out as dead
  always_ff @(posedge clock) begin
    if (reset) begin
      alive_0_sync <= '0;
      alive_1_sync <= '0;
    end else begin
      alive_0_sync <= {alive_0_sync[SYNC_STAGES-2:0], clock_0_alive};
      alive_1_sync <= {alive_1_sync[SYNC_STAGES-2:0], clock_1_alive};
    end
  end

  assign target_alive = request_select ? alive_1_sync[SYNC_STAGES-1]
                                       : alive_0_sync[SYNC_STAGES-1];

  always_comb begin
    state_n   = state;
    count_n   = count;
    select_n  = select;
    rsp_vld_n = 1'b0;
    rsp_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (request_valid) begin
          if (request_select == select) begin
            rsp_vld_n = 1'b1;
          end else if (!target_alive) begin
            rsp_vld_n = 1'b1;
            rsp_err_n = 1'b1;
          end else begin
            select_n = request_select;
            state_n  = SETTLE;
            count_n  = SETTLE_LOAD;
          end
        end
      end
      SETTLE: begin
        // Counter is loaded with N-1 so expiry lands exactly N edges after the select change
        if (count == '0) begin
          rsp_vld_n = 1'b1;
          if (DWELL_CYCLES == 0) begin
            state_n = IDLE;
          end else begin
            state_n = DWELL;
            count_n = DWELL_LOAD;
          end
        end else begin
          count_n = count - 1'b1;
        end
      end
      DWELL: begin
        if (count == '0) begin
          state_n = IDLE;
        end else begin
          count_n = count - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
  end

  // State, select and response registers; reset drops any pending response
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      select         <= RESET_SELECT;
      response_valid <= 1'b0;
      response_error <= 1'b0;
    end else begin
      state          <= state_n;
      count          <= count_n;
      select         <= select_n;
      response_valid <= rsp_vld_n;
      response_error <= rsp_err_n;
    end
  end

  assign request_ready = (state == IDLE) && !reset;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_clock_switch_sequencer.sv
// Randomized scoreboard bench for clock_switch_sequencer: two configurations share one stimulus stream.
module tb_clock_switch_sequencer;

  localparam int SYNC = 2;
  localparam int S0 = 8, D0 = 16;
  localparam int S1 = 1, D1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, rv = 1'b0, rs = 1'b0, a0 = 1'b1, a1 = 1'b1;
  logic [1:0] rdy, rvld, rerr, sel, bsy;

  clock_switch_sequencer #(
    .SETTLE_CYCLES(S0), .DWELL_CYCLES(D0), .SYNC_STAGES(SYNC), .RESET_SELECT(1'b0)
  ) u_a (
    .clock(clk), .reset(rst), .request_valid(rv), .request_select(rs),
    .request_ready(rdy[0]), .response_valid(rvld[0]), .response_error(rerr[0]),
    .clock_0_alive(a0), .clock_1_alive(a1), .select(sel[0]), .busy(bsy[0])
  );

  clock_switch_sequencer #(
    .SETTLE_CYCLES(S1), .DWELL_CYCLES(D1), .SYNC_STAGES(SYNC), .RESET_SELECT(1'b1)
  ) u_b (
    .clock(clk), .reset(rst), .request_valid(rv), .request_select(rs),
    .request_ready(rdy[1]), .response_valid(rvld[1]), .response_error(rerr[1]),
    .clock_0_alive(a0), .clock_1_alive(a1), .select(sel[1]), .busy(bsy[1])
  );

  typedef struct {
    int e;
    bit err;
  } rsp_t;

  rsp_t q0[$];
  rsp_t q1[$];
  int   idle_edge[2];
  int   accept_edge[2];
  bit   m_sel[2];
  bit   h0[0:4095];
  bit   h1[0:4095];
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  function automatic int sc(int i);
    return (i == 0) ? S0 : S1;
  endfunction

  function automatic int dc(int i);
    return (i == 0) ? D0 : D1;
  endfunction

  // Alive level the DUT sees when deciding at edge e: what entered the chain SYNC edges earlier
  function automatic bit synced(bit which, int e);
    int k;
    k = e - SYNC;
    if (k < 1) return 1'b0;
    return which ? h1[k] : h0[k];
  endfunction

  task automatic push_rsp(int i, int e, bit err);
    rsp_t r;
    r.e   = e;
    r.err = err;
    if (i == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  task automatic check(int i, string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d edge %0d: got %b expected %b", nm, i, edge_n, act, exp);
    end
  endtask

  // Transaction-level reference: decides acceptance and outcome from elapsed-time rules
  task automatic model_edge();
    h0[edge_n] = rst ? 1'b0 : a0;
    h1[edge_n] = rst ? 1'b0 : a1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        idle_edge[i] = edge_n;
        m_sel[i]     = (i == 1);
        if (i == 0) q0.delete();
        else        q1.delete();
      end else if (rv && (edge_n - 1 >= idle_edge[i])) begin
        accept_edge[i] = edge_n;
        if (rs == m_sel[i]) begin
          push_rsp(i, edge_n, 1'b0);
        end else if (!synced(rs, edge_n)) begin
          push_rsp(i, edge_n, 1'b1);
        end else begin
          m_sel[i]     = rs;
          push_rsp(i, edge_n + sc(i), 1'b0);
          idle_edge[i] = edge_n + sc(i) + dc(i);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
  endtask

  task automatic req1(bit s);
    rv = 1'b1;
    rs = s;
    tick();
    rv = 1'b0;
  endtask

  always @(negedge clk) begin
    bit exp_v;
    bit exp_e;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        exp_v = 1'b0;
        exp_e = 1'b0;
        if (i == 0 && q0.size() > 0 && q0[0].e == edge_n) begin
          exp_v = 1'b1;
          exp_e = q0[0].err;
          void'(q0.pop_front());
        end else if (i == 1 && q1.size() > 0 && q1[0].e == edge_n) begin
          exp_v = 1'b1;
          exp_e = q1[0].err;
          void'(q1.pop_front());
        end
        check(i, "select", sel[i], m_sel[i]);
        check(i, "busy", bsy[i], edge_n < idle_edge[i]);
        check(i, "request_ready", rdy[i], (edge_n >= idle_edge[i]) && !rst);
        check(i, "response_valid", rvld[i], exp_v);
        if (exp_v) check(i, "response_error", rerr[i], exp_e);
      end
    end
  end

  initial begin
    int prev;
    idle_edge   = '{0, 0};
    accept_edge = '{0, 0};
    m_sel       = '{1'b0, 1'b1};

    tick();
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // First switch to clock 1, then a no-op, then back to 0 and a no-op on 0
    req1(1'b1);
    repeat (30) tick();
    req1(1'b1);
    repeat (5) tick();
    req1(1'b0);
    repeat (30) tick();
    req1(1'b0);
    repeat (3) tick();

    // Dead target refused, then accepted once alive has crossed the synchronizer
    a1 = 1'b0;
    repeat (10) tick();
    req1(1'b1);
    a1 = 1'b1;
    repeat (2) tick();
    req1(1'b1);
    repeat (10) tick();

    // Request held through DWELL: exactly one acceptance once ready
    rv = 1'b1;
    rs = 1'b0;
    prev = accept_edge[0];
    for (int k = 0; k < 100 && accept_edge[0] == prev; k++) tick();
    rv = 1'b0;
    checks++;
    if (accept_edge[0] == prev) begin
      errors++;
      $display("FAIL held_request_timeout inst0 edge %0d: got no acceptance expected one", edge_n);
    end
    repeat (30) tick();

    // Reset in the middle of SETTLE drops the pending response
    req1(1'b1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      rv = ($urandom_range(0, 2) == 0);
      rs = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 19) == 0) a0 = ~a0;
      if ($urandom_range(0, 19) == 0) a1 = ~a1;
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rv  = 1'b0;
    rst = 1'b0;
    repeat (40) tick();

    check(0, "drained", q0.size() == 0, 1'b1);
    check(1, "drained", q1.size() == 0, 1'b1);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
